ad9911_spi_writer: RTL and testbench

Serial register writer for one AD9911 DDS (LO or RF channel board). It converts a parallel register-write request into the AD9911 3-wire serial frame on SCLK/SDIO0 and optionally pulses IO_UPDATE afterwards. It also generates the power-up master-reset sequence. It sits directly upstream of the DDS pin stage and drives the AD9911_*_SCLK, *_SDIO[0], *_UPDATE and *_MRSET nets that the top level forwards to the chip; CS and PD are tied low at top level.

---
 rtl/ad9911_spi_writer_if.sv | 36 +++
 rtl/ad9911_spi_writer.sv | 244 ++++++++++++++++++++++++
 tb/tb_ad9911_spi_writer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9911_spi_writer_if.sv
//-----------------------------------------------------------------------------
// ad9911_spi_writer_if
//
// Register-write request bus between a controller and ad9911_spi_writer.
//
//   WR_REQ     request strobe (controller -> writer)
//   WR_ADDR    5-bit AD9911 register address
//   WR_DATA    32-bit register data, right-aligned
//   WR_UPDATE  pulse IO_UPDATE after the frame
//   WR_BUSY    writer is not idle (writer -> controller)
//   WR_DONE    one-cycle completion pulse
//   WR_ERR     one-cycle, with WR_DONE, when the address was rejected
//
// Modports: master = controller side, slave = writer side.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

interface ad9911_spi_writer_if;
    logic        WR_REQ;
    logic [4:0]  WR_ADDR;
    logic [31:0] WR_DATA;
    logic        WR_UPDATE;
    logic        WR_BUSY;
    logic        WR_DONE;
    logic        WR_ERR;

    modport master (
        output WR_REQ, WR_ADDR, WR_DATA, WR_UPDATE,
        input  WR_BUSY, WR_DONE, WR_ERR
    );

    modport slave (
        input  WR_REQ, WR_ADDR, WR_DATA, WR_UPDATE,
        output WR_BUSY, WR_DONE, WR_ERR
    );
endinterface

// File: rtl/ad9911_spi_writer.sv
//-----------------------------------------------------------------------------
// ad9911_spi_writer
//
// Serial register writer for one AD9911 DDS. A parallel write request is
// turned into the 3-wire frame {instruction byte, N data bytes} on
// SCLK/SDIO0 (MSB first, chip samples on SCLK rise), optionally followed by
// an IO_UPDATE pulse. Invalid register addresses are rejected without any
// pin activity.
//
// Optional feature macro: AD9911_INIT_RESET_EN
//   defined   : every reset runs the power-up sequence (MRSET high for
//               MRSET_CYCLES, then low for MRSET_CYCLES) before IDLE.
//   undefined : reset goes straight to IDLE, MRSET is held low.
//
// Parameters:
//   CLK_DIV       SCLK half-period in clock cycles (>= 1)
//   UPDATE_WIDTH  IO_UPDATE pulse width in clock cycles (>= 1)
//   MRSET_CYCLES  MRSET high time and post-reset wait time (>= 1)
//
// Ports:
//   CLOCK_40M      system clock, rising edge
//   RESET          synchronous, active-high reset
//   wr             request bus (slave side), see ad9911_spi_writer_if
//   AD9911_SCLK    serial clock, idles low
//   AD9911_SDIO0   serial data
//   AD9911_UPDATE  IO_UPDATE
//   AD9911_MRSET   master reset
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ad9911_spi_writer #(
    parameter int CLK_DIV      = 4,
    parameter int UPDATE_WIDTH = 8,
    parameter int MRSET_CYCLES = 400
) (
    input  logic                      CLOCK_40M,
    input  logic                      RESET,
    ad9911_spi_writer_if.slave        wr,
    output logic                      AD9911_SCLK,
    output logic                      AD9911_SDIO0,
    output logic                      AD9911_UPDATE,
    output logic                      AD9911_MRSET
);

    if (CLK_DIV < 1 || UPDATE_WIDTH < 1 || MRSET_CYCLES < 1) begin : g_bad_param
        $error("ad9911_spi_writer: CLK_DIV, UPDATE_WIDTH and MRSET_CYCLES must be >= 1");
    end

    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_SHIFT  = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
`ifdef AD9911_INIT_RESET_EN
    localparam logic [2:0] ST_INIT_RST  = 3'd0;
    localparam logic [2:0] ST_INIT_WAIT = 3'd1;
    localparam logic [2:0] ST_RESET     = ST_INIT_RST;
`else
    localparam logic [2:0] ST_RESET     = ST_IDLE;
`endif

    // Phase counter spans one full SCLK period (low half then high half).
    localparam int              PH_W    = $clog2(2 * CLK_DIV);
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_END  = PH_W'(2 * CLK_DIV - 1);

    localparam int               UPD_W   = $clog2(UPDATE_WIDTH + 1);
    localparam logic [UPD_W-1:0] UPD_END = UPD_W'(UPDATE_WIDTH - 1);

    // Number of data bytes for a register; 0 marks an invalid address.
    function automatic logic [2:0] byte_count(input logic [4:0] addr);
        logic [2:0] n;
        case (addr)
            5'h00:                      n = 3'd1;
            5'h01, 5'h03, 5'h06:        n = 3'd3;
            5'h02, 5'h05, 5'h07:        n = 3'd2;
            5'h19, 5'h1A, 5'h1B, 5'h1C,
            5'h1D, 5'h1E, 5'h1F:        n = 3'd0;
            default:                    n = 3'd4;
        endcase
        return n;
    endfunction

    // Frame left-aligned in 40 bits: instruction byte then the low N data
    // bytes moved up so the first data bit sits right below the address.
    function automatic logic [39:0] build_frame(input logic [4:0]  addr,
                                                input logic [31:0] data,
                                                input logic [2:0]  n);
        logic [31:0] aligned;
        aligned = data << (6'd32 - {n, 3'b000});
        return {1'b0, 2'b00, addr, aligned};
    endfunction

    logic [2:0]       state;
    logic [39:0]      sr;
    logic [5:0]       bit_cnt;
    logic [PH_W-1:0]  ph_cnt;
    logic [UPD_W-1:0] upd_cnt;
    logic             upd_lat;
    logic             sclk_q;
    logic             sdio_q;
    logic             update_q;
    logic             done_q;
    logic             err_q;

    logic [2:0]       req_n;
    logic [39:0]      req_frame;
    logic [5:0]       req_last_bit;

    assign req_n        = byte_count(wr.WR_ADDR);
    assign req_frame    = build_frame(wr.WR_ADDR, wr.WR_DATA, req_n);
    // Index of the last bit of an 8+8N bit frame, counted down to zero.
    assign req_last_bit = {req_n, 3'b000} + 6'd7;

`ifdef AD9911_INIT_RESET_EN
    localparam int              MR_W        = $clog2(MRSET_CYCLES + 1);
    localparam logic [MR_W-1:0] MR_END      = MR_W'(MRSET_CYCLES);
    localparam logic [MR_W-1:0] MR_WAIT_END = MR_W'(MRSET_CYCLES - 1);

    logic            mrset_q;
    logic [MR_W-1:0] init_cnt;
`endif

    always_ff @(posedge CLOCK_40M) begin
        if (RESET) begin
            state    <= ST_RESET;
            sclk_q   <= 1'b0;
            sdio_q   <= 1'b0;
            update_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef AD9911_INIT_RESET_EN
            mrset_q  <= 1'b0;
            init_cnt <= '0;
`endif
        end else begin
            case (state)
`ifdef AD9911_INIT_RESET_EN
                // The first INIT_RST cycle after reset still shows MRSET low,
                // so MRSET is high for exactly MRSET_CYCLES cycles after it.
                ST_INIT_RST: begin
                    if (init_cnt == MR_END) begin
                        mrset_q  <= 1'b0;
                        init_cnt <= '0;
                        state    <= ST_INIT_WAIT;
                    end else begin
                        mrset_q  <= 1'b1;
                        init_cnt <= init_cnt + 1'b1;
                    end
                end

                ST_INIT_WAIT: begin
                    if (init_cnt == MR_WAIT_END) begin
                        init_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
`endif

                ST_IDLE: begin
                    if (wr.WR_REQ) begin
                        if (req_n == 3'd0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state   <= ST_SHIFT;
                            sr      <= req_frame;
                            sdio_q  <= req_frame[39];
                            sclk_q  <= 1'b0;
                            ph_cnt  <= '0;
                            bit_cnt <= req_last_bit;
                            upd_lat <= wr.WR_UPDATE;
                        end
                    end
                end

                // Each bit: CLK_DIV cycles low (data set on entry), then
                // CLK_DIV cycles high; next bit's data changes as SCLK falls.
                ST_SHIFT: begin
                    if (ph_cnt == PH_RISE) begin
                        sclk_q <= 1'b1;
                    end
                    if (ph_cnt == PH_END) begin
                        sclk_q <= 1'b0;
                        ph_cnt <= '0;
                        if (bit_cnt == 6'd0) begin
                            sdio_q <= 1'b0;
                            if (upd_lat) begin
                                state    <= ST_UPDATE;
                                update_q <= 1'b1;
                                upd_cnt  <= '0;
                            end else begin
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            sr      <= sr << 1;
                            sdio_q  <= sr[38];
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                ST_UPDATE: begin
                    if (upd_cnt == UPD_END) begin
                        update_q <= 1'b0;
                        state    <= ST_DONE;
                        done_q   <= 1'b1;
                    end else begin
                        upd_cnt <= upd_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

    assign wr.WR_BUSY  = (state != ST_IDLE);
    assign wr.WR_DONE  = done_q;
    assign wr.WR_ERR   = err_q;

    assign AD9911_SCLK   = sclk_q;
    assign AD9911_SDIO0  = sdio_q;
    assign AD9911_UPDATE = update_q;
`ifdef AD9911_INIT_RESET_EN
    assign AD9911_MRSET  = mrset_q;
`else
    assign AD9911_MRSET  = 1'b0;
`endif

endmodule

// File: tb/tb_ad9911_spi_writer.sv
//-----------------------------------------------------------------------------
// tb_ad9911_spi_writer
//
// Directed bench for ad9911_spi_writer with default parameters
// (CLK_DIV=4, UPDATE_WIDTH=8, MRSET_CYCLES=400). Works with or without
// AD9911_INIT_RESET_EN defined.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ad9911_spi_writer;

    localparam int CLK_DIV = 4;
    localparam int MR      = 400;
    localparam int LIMIT   = 400;
`ifdef AD9911_INIT_RESET_EN
    localparam logic INIT_EN = 1'b1;
`else
    localparam logic INIT_EN = 1'b0;
`endif

    logic clk;
    logic RESET;
    logic ad_sclk;
    logic ad_sdio;
    logic ad_update;
    logic ad_mrset;

    int   n_checks;
    int   n_fail;
    logic sdio_seen;

    ad9911_spi_writer_if bus ();

    ad9911_spi_writer dut (
        .CLOCK_40M     (clk),
        .RESET         (RESET),
        .wr            (bus),
        .AD9911_SCLK   (ad_sclk),
        .AD9911_SDIO0  (ad_sdio),
        .AD9911_UPDATE (ad_update),
        .AD9911_MRSET  (ad_mrset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request in the current cycle t and return at the middle of t+1.
    task automatic start(input logic [4:0] addr, input logic [31:0] data, input logic upd);
        bus.WR_REQ    = 1'b1;
        bus.WR_ADDR   = addr;
        bus.WR_DATA   = data;
        bus.WR_UPDATE = upd;
        @(negedge clk);
    endtask

    // Watch a transaction from cycle t+1 (c=1) until WR_DONE; at c=1 the
    // request inputs are replaced by the nxt_* values.
    task automatic run_frame(input string       tag,
                             input int          nbits,
                             input logic [39:0] exp_bits,
                             input int          exp_done_c,
                             input int          exp_upd_first,
                             input int          exp_upd_n,
                             input logic        exp_err,
                             input logic        nxt_req,
                             input logic [4:0]  nxt_addr,
                             input logic [31:0] nxt_data,
                             input logic        nxt_upd);
        logic [39:0] bits;
        logic        prev_sclk, prev_sdio, unstable, busy1, err_at;
        int          rises, last_high, upd_n, upd_first, done_c;
        bits = '0; prev_sclk = 1'b0; prev_sdio = 1'b0; unstable = 1'b0;
        busy1 = 1'b0; err_at = 1'b0;
        rises = 0; last_high = 0; upd_n = 0; upd_first = 0; done_c = 0;
        sdio_seen = 1'b0;
        for (int c = 1; c <= LIMIT; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1) begin
                busy1         = bus.WR_BUSY;
                bus.WR_REQ    = nxt_req;
                bus.WR_ADDR   = nxt_addr;
                bus.WR_DATA   = nxt_data;
                bus.WR_UPDATE = nxt_upd;
            end
            if (ad_sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                bits = {bits[38:0], ad_sdio};
            end
            if (ad_sclk === 1'b1 && ad_sdio !== prev_sdio) unstable = 1'b1;
            if (ad_sclk === 1'b1) last_high = c;
            if (ad_update === 1'b1) begin
                upd_n++;
                if (upd_first == 0) upd_first = c;
            end
            if (ad_sdio === 1'b1) sdio_seen = 1'b1;
            prev_sclk = ad_sclk;
            prev_sdio = ad_sdio;
            if (bus.WR_DONE === 1'b1) begin
                done_c = c;
                err_at = bus.WR_ERR;
                break;
            end
        end
        check({tag, "_busy_t1"},   64'(busy1), 64'(1));
        check({tag, "_rises"},     64'(rises), 64'(nbits));
        check({tag, "_bits"},      64'(bits), 64'(exp_bits));
        check({tag, "_last_high"}, 64'(last_high), 64'(nbits * 2 * CLK_DIV));
        check({tag, "_sdio_hold"}, 64'(unstable), 64'(0));
        check({tag, "_upd_n"},     64'(upd_n), 64'(exp_upd_n));
        check({tag, "_upd_first"}, 64'(upd_first), 64'(exp_upd_first));
        check({tag, "_done_c"},    64'(done_c), 64'(exp_done_c));
        check({tag, "_err"},       64'(err_at), 64'(exp_err));
    endtask

    task automatic post_done(input string tag);
        @(negedge clk);
        check({tag, "_done_clr"}, 64'(bus.WR_DONE), 64'(0));
        check({tag, "_err_clr"},  64'(bus.WR_ERR), 64'(0));
        check({tag, "_idle"},     64'(bus.WR_BUSY), 64'(0));
    endtask

`ifdef AD9911_INIT_RESET_EN
    // RESET was released at a falling edge; cycle k follows the k-th rising
    // edge that samples RESET low.
    task automatic check_init(input string tag);
        logic bad_mr, bad_busy, act;
        int   hi;
        bad_mr = 1'b0; bad_busy = 1'b0; act = 1'b0; hi = 0;
        for (int k = 1; k <= 2 * MR + 1; k++) begin
            @(posedge clk);
            #1;
            if (ad_mrset !== (k <= MR)) bad_mr = 1'b1;
            if (ad_mrset === 1'b1) hi++;
            if (bus.WR_BUSY !== (k < 2 * MR + 1)) bad_busy = 1'b1;
            if (ad_sclk !== 1'b0 || bus.WR_DONE !== 1'b0 || ad_update !== 1'b0) act = 1'b1;
        end
        check({tag, "_mrset_shape"}, 64'(bad_mr), 64'(0));
        check({tag, "_mrset_len"},   64'(hi), 64'(MR));
        check({tag, "_busy_shape"},  64'(bad_busy), 64'(0));
        check({tag, "_quiet"},       64'(act), 64'(0));
        @(negedge clk);
    endtask
`endif

    initial begin
        logic quiet;
        n_checks      = 0;
        n_fail        = 0;
        RESET         = 1'b1;
        bus.WR_REQ    = 1'b0;
        bus.WR_ADDR   = '0;
        bus.WR_DATA   = '0;
        bus.WR_UPDATE = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_sclk",  64'(ad_sclk), 64'(0));
        check("rst_sdio",  64'(ad_sdio), 64'(0));
        check("rst_upd",   64'(ad_update), 64'(0));
        check("rst_mrset", 64'(ad_mrset), 64'(0));
        check("rst_done",  64'(bus.WR_DONE), 64'(0));
        check("rst_err",   64'(bus.WR_ERR), 64'(0));
        check("rst_busy",  64'(bus.WR_BUSY), 64'(INIT_EN));
        RESET = 1'b0;
`ifdef AD9911_INIT_RESET_EN
        check_init("init");
`else
        @(negedge clk);
        check("idle_after_rst", 64'(bus.WR_BUSY), 64'(0));
`endif

        // 4-byte register with IO_UPDATE: T = 40*8 = 320.
        start(5'h04, 32'h1999_999A, 1'b1);
        run_frame("f1", 40, 40'h04_1999_999A, 329, 321, 8, 1'b0,
                  1'b0, 5'h1F, 32'hFFFF_FFFF, 1'b0);
        post_done("f1");

        // 1-byte register, no update; changed inputs after acceptance.
        start(5'h00, 32'hABCD_12F0, 1'b0);
        run_frame("f2", 16, 40'h00_0000_00F0, 129, 0, 0, 1'b0,
                  1'b0, 5'h19, 32'h0000_0000, 1'b1);
        post_done("f2");

        // Invalid address: immediate DONE+ERR, no pin activity.
        start(5'h1A, 32'hFFFF_FFFF, 1'b1);
        run_frame("bad", 0, 40'h0, 1, 0, 0, 1'b1,
                  1'b0, 5'h00, 32'h0000_0000, 1'b0);
        check("bad_sdio_quiet", 64'(sdio_seen), 64'(0));
        post_done("bad");

        // Request held high through a 2-byte frame; it is taken again the
        // cycle after WR_DONE with the values present then.
        start(5'h07, 32'h0000_1234, 1'b0);
        run_frame("held1", 24, 40'h00_0007_1234, 193, 0, 0, 1'b0,
                  1'b1, 5'h00, 32'h0000_005A, 1'b0);
        @(negedge clk);
        check("held_gap_idle", 64'(bus.WR_BUSY), 64'(0));
        @(negedge clk);
        run_frame("held2", 16, 40'h00_0000_005A, 129, 0, 0, 1'b0,
                  1'b0, 5'h00, 32'h0000_0000, 1'b0);
        post_done("held2");

        // Reset during the high phase of bit 10 (cycles 77..80 of the frame).
        start(5'h04, 32'hFFFF_FFFF, 1'b1);
        bus.WR_REQ = 1'b0;
        repeat (77) @(negedge clk);
        check("pre_abort_sclk", 64'(ad_sclk), 64'(1));
        check("pre_abort_sdio", 64'(ad_sdio), 64'(1));
        RESET = 1'b1;
        @(negedge clk);
        check("abort_sclk",  64'(ad_sclk), 64'(0));
        check("abort_sdio",  64'(ad_sdio), 64'(0));
        check("abort_upd",   64'(ad_update), 64'(0));
        check("abort_done",  64'(bus.WR_DONE), 64'(0));
        check("abort_mrset", 64'(ad_mrset), 64'(0));
        check("abort_busy",  64'(bus.WR_BUSY), 64'(INIT_EN));
        RESET = 1'b0;
`ifdef AD9911_INIT_RESET_EN
        check_init("reinit");
`else
        quiet = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.WR_DONE !== 1'b0 || ad_sclk !== 1'b0 || ad_update !== 1'b0 ||
                bus.WR_BUSY !== 1'b0) quiet = 1'b0;
        end
        check("abort_quiet", 64'(quiet), 64'(1));
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
